// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: host command sequencer between the SPI byte slave and the
// ADC capture engine. Parses 5A-framed commands one byte at a time, holds the
// capture configuration, arms captures and streams buffer bytes or a status
// byte back on tx_data.
// Build option: define SPI_CMD_CHECKSUM_EN to require a fifth CONFIG payload
// byte equal to the XOR of the four payload bytes.
// ADDR_W is limited to 15 so the 16-bit host length field covers cap_len.
module spi_cmd_ctrl #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [7:0]  SYNC_BYTE = 8'h5A
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              frame_active,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic [7:0]        tx_data,
   output logic              cap_start,
   output logic [7:0]        cap_div,
   output logic [ADDR_W:0]   cap_len,
   output logic [7:0]        trig_level,
   input  logic              cap_busy,
   input  logic              cap_done,
   output logic [ADDR_W-1:0] buf_raddr,
   input  logic [7:0]        buf_rdata,
   output logic [7:0]        err_cnt
);

   localparam logic [7:0] OP_CONFIG = 8'h01;
   localparam logic [7:0] OP_ARM    = 8'h02;
   localparam logic [7:0] OP_READ   = 8'h03;
   localparam logic [7:0] OP_STATUS = 8'h04;

`ifdef SPI_CMD_CHECKSUM_EN
   localparam int unsigned PAY_N = 5;
`else
   localparam int unsigned PAY_N = 4;
`endif
   // All payload bytes except the last are held; the last is used straight off rx_data.
   localparam int unsigned PAY_STORE = PAY_N - 1;
   localparam logic [2:0]  LAST_IDX  = 3'(PAY_N - 1);
   localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPC,
      S_CFG,
      S_READ,
      S_STAT
   } state_t;

   state_t            state_reg;
   logic [2:0]        pay_idx_reg;
   logic [7:0]        tx_data_reg;
   logic              cap_start_reg;
   logic [7:0]        cap_div_reg;
   logic [ADDR_W:0]   cap_len_reg;
   logic [7:0]        trig_level_reg;
   logic [ADDR_W-1:0] buf_raddr_reg;
   logic [7:0]        err_cnt_reg;
   logic              done_sticky_reg;
   logic              cfg_valid_reg;
   logic              rd_p1_reg;
   logic              rd_p2_reg;

   logic              byte_evt;
   logic [7:0]        pay_byte [PAY_STORE];
   logic [7:0]        cfg_div_next;
   logic [15:0]       cfg_len_raw;
   logic [ADDR_W:0]   cfg_len_next;
   logic [7:0]        cfg_trig_next;
   logic              cfg_ok;
   logic [7:0]        err_cnt_next;
   logic [7:0]        status_byte;
   logic [ADDR_W:0]   len_m1;
   logic              raddr_last;

   // A byte only counts while the frame is open; a closed frame aborts instead.
   assign byte_evt = rx_valid & frame_active;

   // Payload byte store, one register per payload position.
   genvar gi;
   generate
      for (gi = 0; gi < PAY_STORE; gi++) begin : g_pay
         logic [7:0] byte_reg;

         // Latch payload position gi when it arrives during CONFIG collection.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
               byte_reg <= 8'h00;
            else if (byte_evt && (state_reg == S_CFG) && (pay_idx_reg == 3'(gi)))
               byte_reg <= rx_data;
         end

         assign pay_byte[gi] = byte_reg;
      end
   endgenerate

   // Decode the candidate configuration as it stands on the final payload byte.
   always_comb begin
      cfg_div_next = pay_byte[0];
      cfg_len_raw  = {pay_byte[2], pay_byte[1]};
`ifdef SPI_CMD_CHECKSUM_EN
      cfg_trig_next = pay_byte[3];
      cfg_ok = (cfg_len_raw != 16'h0000) &&
               (rx_data == (pay_byte[0] ^ pay_byte[1] ^ pay_byte[2] ^ pay_byte[3]));
`else
      cfg_trig_next = rx_data;
      cfg_ok = (cfg_len_raw != 16'h0000);
`endif
      // Oversized lengths clamp to the full buffer rather than being rejected.
      if (cfg_len_raw > 16'(LEN_MAX))
         cfg_len_next = LEN_MAX;
      else
         cfg_len_next = cfg_len_raw[ADDR_W:0];
   end

   // Error counter sticks at its top value.
   always_comb begin
      err_cnt_next = err_cnt_reg;
      if (err_cnt_reg != 8'hFF)
         err_cnt_next = err_cnt_reg + 8'd1;
   end

   // Status snapshot and end-of-read detection.
   always_comb begin
      status_byte = {4'h0, cfg_valid_reg, (err_cnt_reg != 8'h00), done_sticky_reg, cap_busy};
      len_m1      = cap_len_reg - {{ADDR_W{1'b0}}, 1'b1};
      raddr_last  = ({1'b0, buf_raddr_reg} == len_m1);
   end

   // Command FSM with registered outputs; everything moves on a byte boundary
   // except the abort, the read-data pipeline and the done flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg       <= S_IDLE;
         pay_idx_reg     <= 3'd0;
         tx_data_reg     <= 8'h00;
         cap_start_reg   <= 1'b0;
         cap_div_reg     <= 8'd1;
         cap_len_reg     <= LEN_MAX;
         trig_level_reg  <= 8'h80;
         buf_raddr_reg   <= '0;
         err_cnt_reg     <= 8'h00;
         done_sticky_reg <= 1'b0;
         cfg_valid_reg   <= 1'b0;
         rd_p1_reg       <= 1'b0;
         rd_p2_reg       <= 1'b0;
      end else begin
         cap_start_reg <= 1'b0;
         rd_p1_reg     <= 1'b0;
         rd_p2_reg     <= rd_p1_reg;
         // Buffer data lands two cycles after the advancing byte: one for the
         // address register, one for the RAM's registered read.
         if (rd_p2_reg)
            tx_data_reg <= buf_rdata;
         if (cap_done)
            done_sticky_reg <= 1'b1;

         if (!frame_active) begin
            state_reg   <= S_IDLE;
            pay_idx_reg <= 3'd0;
            tx_data_reg <= 8'h00;
            rd_p2_reg   <= 1'b0;
         end else if (rx_valid) begin
            // Slots not carrying status or buffer data send zero.
            tx_data_reg <= 8'h00;
            case (state_reg)
               S_IDLE: begin
                  if (rx_data == SYNC_BYTE)
                     state_reg <= S_OPC;
               end
               S_OPC: begin
                  state_reg <= S_IDLE;
                  case (rx_data)
                     OP_CONFIG: begin
                        state_reg   <= S_CFG;
                        pay_idx_reg <= 3'd0;
                     end
                     OP_ARM: begin
                        if (cap_busy) begin
                           err_cnt_reg <= err_cnt_next;
                        end else begin
                           cap_start_reg   <= 1'b1;
                           // Overrides a cap_done landing in this same cycle.
                           done_sticky_reg <= 1'b0;
                        end
                     end
                     OP_READ: begin
                        if (cap_busy) begin
                           err_cnt_reg <= err_cnt_next;
                        end else begin
                           state_reg     <= S_READ;
                           buf_raddr_reg <= '0;
                           rd_p1_reg     <= 1'b1;
                        end
                     end
                     OP_STATUS: begin
                        state_reg   <= S_STAT;
                        tx_data_reg <= status_byte;
                     end
                     default: err_cnt_reg <= err_cnt_next;
                  endcase
               end
               S_CFG: begin
                  if (pay_idx_reg == LAST_IDX) begin
                     state_reg <= S_IDLE;
                     if (cfg_ok) begin
                        cap_div_reg    <= cfg_div_next;
                        cap_len_reg    <= cfg_len_next;
                        trig_level_reg <= cfg_trig_next;
                        cfg_valid_reg  <= 1'b1;
                     end else begin
                        err_cnt_reg <= err_cnt_next;
                     end
                  end else begin
                     pay_idx_reg <= pay_idx_reg + 3'd1;
                  end
               end
               S_READ: begin
                  // Received bytes are don't-care; each boundary advances the stream.
                  if (raddr_last) begin
                     state_reg <= S_IDLE;
                  end else begin
                     buf_raddr_reg <= buf_raddr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
                     rd_p1_reg     <= 1'b1;
                  end
               end
               S_STAT: state_reg <= S_IDLE;
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

   assign tx_data    = tx_data_reg;
   assign cap_start  = cap_start_reg;
   assign cap_div    = cap_div_reg;
   assign cap_len    = cap_len_reg;
   assign trig_level = trig_level_reg;
   assign buf_raddr  = buf_raddr_reg;
   assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed command frames with hand-computed
// responses. Each sent byte queues the tx byte expected in the following
// slot; a monitor pops and compares a few cycles after every byte boundary.
module tb_spi_cmd_ctrl;

   localparam int ADDR_W = 12;

   logic              clk;
   logic              rstn;
   logic              frame_active;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic [7:0]        tx_data;
   logic              cap_start;
   logic [7:0]        cap_div;
   logic [ADDR_W:0]   cap_len;
   logic [7:0]        trig_level;
   logic              cap_busy;
   logic              cap_done;
   logic [ADDR_W-1:0] buf_raddr;
   logic [7:0]        buf_rdata;
   logic [7:0]        err_cnt;

   logic [7:0] mem [0:(1<<ADDR_W)-1];
   logic [7:0] exp_q [$];
   int         checks;
   int         errors;
   int         start_cnt;

   spi_cmd_ctrl #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'h5A)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .frame_active (frame_active),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .tx_data      (tx_data),
      .cap_start    (cap_start),
      .cap_div      (cap_div),
      .cap_len      (cap_len),
      .trig_level   (trig_level),
      .cap_busy     (cap_busy),
      .cap_done     (cap_done),
      .buf_raddr    (buf_raddr),
      .buf_rdata    (buf_rdata),
      .err_cnt      (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture buffer model: registered read.
   always @(posedge clk) buf_rdata <= mem[buf_raddr];

   always @(negedge clk) if (cap_start) start_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: after each accepted byte, the next-slot tx byte must match.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk);
         if (rstn && frame_active && rx_valid) begin
            repeat (4) @(negedge clk);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL slot_unexpected actual=%0h required=none", tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("slot", 32'(tx_data), 32'(e));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_tx,
                            input bit exp_start, input bit done_pulse);
      exp_q.push_back(exp_tx);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      cap_done = done_pulse;
      @(negedge clk);
      rx_valid = 1'b0;
      cap_done = 1'b0;
      chk("cap_start", 32'(cap_start), 32'(exp_start));
      @(negedge clk);
      chk("cap_start_width", 32'(cap_start), 32'd0);
      repeat (17) @(negedge clk);
   endtask

   task automatic sb(input logic [7:0] b, input logic [7:0] exp_tx);
      send_byte(b, exp_tx, 1'b0, 1'b0);
   endtask

   task automatic send_cfg(input logic [7:0] dv, input logic [7:0] lo,
                           input logic [7:0] hi, input logic [7:0] tg);
      sb(8'h5A, 8'h00); sb(8'h01, 8'h00);
      sb(dv, 8'h00); sb(lo, 8'h00); sb(hi, 8'h00); sb(tg, 8'h00);
`ifdef SPI_CMD_CHECKSUM_EN
      sb(dv ^ lo ^ hi ^ tg, 8'h00);
`endif
   endtask

   task automatic status(input logic [7:0] exp_stat);
      sb(8'h5A, 8'h00); sb(8'h04, exp_stat); sb(8'h00, 8'h00);
   endtask

   task automatic chk_cfg(input string tag, input logic [7:0] dv,
                          input logic [12:0] ln, input logic [7:0] tg);
      chk({tag, "_div"}, 32'(cap_div), 32'(dv));
      chk({tag, "_len"}, 32'(cap_len), 32'(ln));
      chk({tag, "_trig"}, 32'(trig_level), 32'(tg));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; start_cnt = 0;
      rstn = 1'b0; frame_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      cap_busy = 1'b0; cap_done = 1'b0;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'hE0 ^ 8'(i);
      for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);

      // Reset state
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_tx", 32'(tx_data), 32'h00);
      chk("rst_start", 32'(cap_start), 32'd0);
      chk_cfg("rst", 8'd1, 13'd4096, 8'h80);
      chk("rst_raddr", 32'(buf_raddr), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      frame_active = 1'b1;
      repeat (3) @(negedge clk);

      // STATUS after reset
      status(8'h00);

      // CONFIG then STATUS
      send_cfg(8'hFF, 8'h05, 8'h00, 8'h11);
      chk_cfg("cfg", 8'hFF, 13'd5, 8'h11);
      status(8'h08);

      // ARM, busy window with a STATUS inside, then cap_done
      sb(8'h5A, 8'h00);
      send_byte(8'h02, 8'h00, 1'b1, 1'b0);
      cap_busy = 1'b1;
      status(8'h09);
      repeat (40) @(negedge clk);
      cap_busy = 1'b0;
      cap_done = 1'b1;
      @(negedge clk);
      cap_done = 1'b0;
      status(8'h0A);

      // Rejections: ARM while busy, bad opcode, zero length
      cap_busy = 1'b1;
      sb(8'h5A, 8'h00); sb(8'h02, 8'h00);
      cap_busy = 1'b0;
      sb(8'h5A, 8'h00); sb(8'h07, 8'h00);
      send_cfg(8'h12, 8'h00, 8'h00, 8'h34);
      chk("rej_err", 32'(err_cnt), 32'd3);
      chk_cfg("rej", 8'hFF, 13'd5, 8'h11);
      status(8'h0E);

      // READ of 5 samples with 7 filler bytes (fillers ignored, even 5A/04)
      sb(8'h5A, 8'h00); sb(8'h03, 8'h01);
      sb(8'h5A, 8'h02); sb(8'h04, 8'h03); sb(8'h00, 8'h04); sb(8'h00, 8'h05);
      sb(8'h00, 8'h00); sb(8'h00, 8'h00); sb(8'h00, 8'h00);
      chk("read_raddr", 32'(buf_raddr), 32'd4);

      // Abort during READ: tx returns to zero
      sb(8'h5A, 8'h00); sb(8'h03, 8'h01);
      frame_active = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_read_tx", 32'(tx_data), 32'h00);
      frame_active = 1'b1;
      repeat (5) @(negedge clk);

      // Abort mid CONFIG: registers unchanged, no error, next frame parses
      sb(8'h5A, 8'h00); sb(8'h01, 8'h00); sb(8'h33, 8'h00); sb(8'h05, 8'h00);
      frame_active = 1'b0;
      repeat (3) @(negedge clk);
      frame_active = 1'b1;
      repeat (5) @(negedge clk);
      sb(8'h00, 8'h00); sb(8'h11, 8'h00);
      chk_cfg("abort", 8'hFF, 13'd5, 8'h11);
      chk("abort_err", 32'(err_cnt), 32'd3);
      status(8'h0E);

`ifdef SPI_CMD_CHECKSUM_EN
      // Wrong checksum byte rejects the frame
      sb(8'h5A, 8'h00); sb(8'h01, 8'h00);
      sb(8'h07, 8'h00); sb(8'h02, 8'h00); sb(8'h00, 8'h00); sb(8'h55, 8'h00);
      sb(8'h07 ^ 8'h02 ^ 8'h00 ^ 8'h55 ^ 8'h01, 8'h00);
      chk("ck_err", 32'(err_cnt), 32'd4);
      chk_cfg("ck", 8'hFF, 13'd5, 8'h11);
`endif

      // ARM coinciding with cap_done: done flag ends up clear
      sb(8'h5A, 8'h00);
      send_byte(8'h02, 8'h00, 1'b1, 1'b1);
      status(8'h0C);

      // Oversized length clamps to full buffer
      send_cfg(8'h02, 8'hFF, 8'hFF, 8'h44);
      chk_cfg("sat", 8'h02, 13'd4096, 8'h44);

      // 300 rejections saturate the error counter
      for (int i = 0; i < 300; i++) begin
         sb(8'h5A, 8'h00); sb(8'h07, 8'h00);
      end
      chk("err_sat", 32'(err_cnt), 32'hFF);

      repeat (10) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("start_count", 32'(start_cnt), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
